// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker that decodes la/lb into a controller phase and
// verifies legal phase sequencing. Optional green timeout check: TLM_GREEN_TIMEOUT_EN.
module traffic_light_monitor #(
   parameter int CNT_W     = 16,
   parameter int DWELL_W   = 8,
   parameter int MAX_GREEN = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         la,
   input  logic [1:0]         lb,
   input  logic               ta,
   input  logic               tb,
   input  logic               clr_err,
   output logic [1:0]         phase,
   output logic               phase_valid,
   output logic               err,
   output logic [2:0]         err_code,
   output logic [DWELL_W-1:0] dwell_cnt,
   output logic [CNT_W-1:0]   cycle_cnt
);

   typedef enum logic [1:0] {
      ST_SYNC  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   localparam logic [1:0] L_GREEN  = 2'b00;
   localparam logic [1:0] L_YELLOW = 2'b01;
   localparam logic [1:0] L_RED    = 2'b10;
   localparam logic [1:0] L_BAD    = 2'b11;

   localparam logic [1:0] S0 = 2'd0;
   localparam logic [1:0] S1 = 2'd1;
   localparam logic [1:0] S2 = 2'd2;
   localparam logic [1:0] S3 = 2'd3;

   localparam logic [2:0] E_NONE    = 3'd0;
   localparam logic [2:0] E_CODE    = 3'd1;
   localparam logic [2:0] E_COMBO   = 3'd2;
   localparam logic [2:0] E_TRANS   = 3'd3;
   localparam logic [2:0] E_TIMEOUT = 3'd4;

`ifdef TLM_GREEN_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [DWELL_W-1:0] GREEN_LAST = DWELL_W'(MAX_GREEN - 1);

   state_t             r_state, w_state_nxt;
   logic [1:0]         r_phase, w_phase_nxt;
   logic [2:0]         r_err_code, w_err_code_nxt;
   logic [DWELL_W-1:0] r_dwell, w_dwell_nxt, w_dwell_inc;
   logic [CNT_W-1:0]   r_cycle, w_cycle_nxt, w_cycle_inc;
   logic               r_ta_q, r_tb_q;

   logic               w_dec_ok;
   logic [1:0]         w_dec_phase;
   logic [2:0]         w_dec_err;
   logic [1:0]         w_exp_phase;
   logic               w_same;
   logic               w_timeout;

   // Light pair decode; an 11 code anywhere outranks a bad combination.
   always_comb begin
      w_dec_ok    = 1'b0;
      w_dec_phase = S0;
      w_dec_err   = E_NONE;
      if (la == L_BAD || lb == L_BAD) begin
         w_dec_err = E_CODE;
      end else begin
         case ({la, lb})
            {L_GREEN,  L_RED}:    begin w_dec_ok = 1'b1; w_dec_phase = S0; end
            {L_YELLOW, L_RED}:    begin w_dec_ok = 1'b1; w_dec_phase = S1; end
            {L_RED,    L_GREEN}:  begin w_dec_ok = 1'b1; w_dec_phase = S2; end
            {L_RED,    L_YELLOW}: begin w_dec_ok = 1'b1; w_dec_phase = S3; end
            default:              w_dec_err = E_COMBO;
         endcase
      end
   end

   always_comb begin
      case (r_phase)
         S0:      w_exp_phase = r_ta_q ? S0 : S1;
         S1:      w_exp_phase = S2;
         S2:      w_exp_phase = r_tb_q ? S2 : S3;
         default: w_exp_phase = S0;
      endcase
   end

   assign w_same      = (w_dec_phase == r_phase);
   assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + DWELL_W'(1);
   assign w_cycle_inc = (&r_cycle) ? r_cycle : r_cycle + CNT_W'(1);

   // Green phases are the even encodings (S0, S2).
   assign w_timeout = TIMEOUT_EN && w_same && !r_phase[0] && (r_dwell == GREEN_LAST);

   always_comb begin
      w_state_nxt    = r_state;
      w_phase_nxt    = r_phase;
      w_err_code_nxt = r_err_code;
      w_dwell_nxt    = r_dwell;
      w_cycle_nxt    = r_cycle;
      if (clr_err) begin
         // Resync request wins over anything seen on this sample.
         w_state_nxt    = ST_SYNC;
         w_err_code_nxt = E_NONE;
         w_dwell_nxt    = '0;
      end else begin
         case (r_state)
            ST_SYNC: begin
               if (w_dec_ok) begin
                  w_phase_nxt = w_dec_phase;
                  w_dwell_nxt = '0;
                  w_state_nxt = ST_TRACK;
               end else begin
                  w_err_code_nxt = w_dec_err;
                  w_state_nxt    = ST_ERROR;
               end
            end
            ST_TRACK: begin
               if (!w_dec_ok) begin
                  w_err_code_nxt = w_dec_err;
                  w_state_nxt    = ST_ERROR;
               end else if (w_dec_phase != w_exp_phase) begin
                  w_err_code_nxt = E_TRANS;
                  w_state_nxt    = ST_ERROR;
               end else if (w_timeout) begin
                  w_err_code_nxt = E_TIMEOUT;
                  w_state_nxt    = ST_ERROR;
               end else begin
                  w_phase_nxt = w_dec_phase;
                  w_dwell_nxt = w_same ? w_dwell_inc : '0;
                  if (r_phase == S3 && w_dec_phase == S0) begin
                     w_cycle_nxt = w_cycle_inc;
                  end
               end
            end
            ST_ERROR: ;
            default: w_state_nxt = ST_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_SYNC;
         r_phase    <= S0;
         r_err_code <= E_NONE;
         r_dwell    <= '0;
         r_cycle    <= '0;
         r_ta_q     <= 1'b0;
         r_tb_q     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_err_code <= w_err_code_nxt;
         r_dwell    <= w_dwell_nxt;
         r_cycle    <= w_cycle_nxt;
         r_ta_q     <= ta;
         r_tb_q     <= tb;
      end
   end

   assign phase       = r_phase;
   assign phase_valid = (r_state == ST_TRACK);
   assign err         = (r_state == ST_ERROR);
   assign err_code    = r_err_code;
   assign dwell_cnt   = r_dwell;
   assign cycle_cnt   = r_cycle;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed plus random stimulus against a phase-rule reference model.
module tb_traffic_light_monitor;

   localparam int CNT_W     = 16;
   localparam int DWELL_W   = 8;
   localparam int MAX_GREEN = 8;
   localparam int DW_MAX    = (1 << DWELL_W) - 1;
   localparam int CYC_MAX   = (1 << CNT_W) - 1;

   logic               clk = 1'b0;
   logic               reset;
   logic [1:0]         la, lb;
   logic               ta, tb, clr_err;
   logic [1:0]         phase;
   logic               phase_valid, err;
   logic [2:0]         err_code;
   logic [DWELL_W-1:0] dwell_cnt;
   logic [CNT_W-1:0]   cycle_cnt;

   traffic_light_monitor #(.CNT_W(CNT_W), .DWELL_W(DWELL_W), .MAX_GREEN(MAX_GREEN)) dut (
      .clk(clk), .reset(reset), .la(la), .lb(lb), .ta(ta), .tb(tb), .clr_err(clr_err),
      .phase(phase), .phase_valid(phase_valid), .err(err), .err_code(err_code),
      .dwell_cnt(dwell_cnt), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   // Light pairs that show each phase: S0 A green, S1 A yellow, S2 B green, S3 B yellow.
   logic [1:0] LA_OF [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
   logic [1:0] LB_OF [4] = '{2'd2, 2'd2, 2'd0, 2'd1};

   int n_cmp = 0;
   int n_bad = 0;

   int m_phase, m_dwell, m_cycles, m_code;
   bit m_trk, m_err, m_ta, m_tb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_dwell = 0; m_cycles = 0; m_code = 0;
      m_trk = 0; m_err = 0; m_ta = 0; m_tb = 0;
   endtask

   function automatic int m_expect();
      if (m_phase == 0) return m_ta ? 0 : 1;
      if (m_phase == 1) return 2;
      if (m_phase == 2) return m_tb ? 2 : 3;
      return 0;
   endfunction

   task automatic model_step(input logic [1:0] a, b, input logic sa, sb, c);
      int dec, bad, exp_p;
      bit tmo;
      dec = -1;
      for (int p = 0; p < 4; p++) if (a == LA_OF[p] && b == LB_OF[p]) dec = p;
      bad   = (a == 2'd3 || b == 2'd3) ? 1 : 2;
      exp_p = m_expect();
      tmo   = 0;
`ifdef TLM_GREEN_TIMEOUT_EN
      tmo = (dec == m_phase) && (m_phase == 0 || m_phase == 2) && (m_dwell == MAX_GREEN - 1);
`endif
      if (c) begin
         m_trk = 0; m_err = 0; m_code = 0; m_dwell = 0;
      end else if (m_err) begin
         m_err = 1;
      end else if (!m_trk) begin
         if (dec >= 0) begin m_phase = dec; m_dwell = 0; m_trk = 1; end
         else begin m_err = 1; m_code = bad; end
      end else if (dec < 0) begin
         m_trk = 0; m_err = 1; m_code = bad;
      end else if (dec != exp_p) begin
         m_trk = 0; m_err = 1; m_code = 3;
      end else if (tmo) begin
         m_trk = 0; m_err = 1; m_code = 4;
      end else begin
         if (m_phase == 3 && dec == 0 && m_cycles < CYC_MAX) m_cycles++;
         if (dec == m_phase) m_dwell = (m_dwell < DW_MAX) ? m_dwell + 1 : m_dwell;
         else m_dwell = 0;
         m_phase = dec;
      end
      m_ta = sa; m_tb = sb;
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".phase"}, 32'(phase), 32'(m_phase));
      check({tag, ".valid"}, 32'(phase_valid), 32'(m_trk));
      check({tag, ".err"},   32'(err), 32'(m_err));
      check({tag, ".code"},  32'(err_code), 32'(m_code));
      check({tag, ".dwell"}, 32'(dwell_cnt), 32'(m_dwell));
      check({tag, ".cycle"}, 32'(cycle_cnt), 32'(m_cycles));
   endtask

   task automatic step(input string tag, input logic [1:0] a, b, input logic sa, sb, c);
      la = a; lb = b; ta = sa; tb = sb; clr_err = c;
      @(posedge clk);
      model_step(a, b, sa, sb, c);
      #1;
      compare_all(tag);
   endtask

   task automatic step_ph(input string tag, input int p, input logic sa, sb);
      step(tag, LA_OF[p], LB_OF[p], sa, sb, 1'b0);
   endtask

   initial begin
      int r, p;
      logic [1:0] ra, rb;
      reset = 1'b1; la = 2'd0; lb = 2'd2; ta = 1'b0; tb = 1'b0; clr_err = 1'b0;
      model_reset();
      #12;
      compare_all("reset");
      reset = 1'b0;

      for (int i = 0; i < 3; i++) step_ph("hold_s0", 0, 1'b1, 1'b0);
      check("hold_s0.dwell2", 32'(dwell_cnt), 32'd2);

      for (int k = 0; k < 3; k++) begin
         step_ph("seq_s0", 0, 1'b0, 1'b0);
         step_ph("seq_s1", 1, 1'b0, 1'b0);
         step_ph("seq_s2", 2, 1'b0, 1'b0);
         step_ph("seq_s3", 3, 1'b0, 1'b0);
      end
      step_ph("seq_end", 0, 1'b1, 1'b0);
      check("seq.cycles3", 32'(cycle_cnt), 32'd3);
      check("seq.dwell0", 32'(dwell_cnt), 32'd0);

      // Car waiting on A: moving to S1 is illegal.
      step_ph("badtr", 1, 1'b1, 1'b0);
      check("badtr.code", 32'(err_code), 32'd3);
      step_ph("frozen", 2, 1'b0, 1'b0);
      step_ph("frozen", 3, 1'b0, 1'b0);
      step("clr", LA_OF[2], LB_OF[2], 1'b0, 1'b0, 1'b1);
      check("clr.err", 32'(err), 32'd0);
      step_ph("resync", 2, 1'b0, 1'b0);
      check("resync.valid", 32'(phase_valid), 32'd1);

      step("code1", 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
      check("code1.code", 32'(err_code), 32'd1);
      step("clr1", 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
      step("code2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
      check("code2.code", 32'(err_code), 32'd2);
      step("clr2", 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 260; i++) step_ph("green_hold", 0, 1'b1, 1'b0);
`ifdef TLM_GREEN_TIMEOUT_EN
      check("green_hold.code4", 32'(err_code), 32'd4);
`else
      check("green_hold.sat", 32'(dwell_cnt), 32'd255);
`endif
      step("clr3", 2'd0, 2'd2, 1'b0, 1'b0, 1'b1);

      step_ph("c5", 0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step_ph("c5", 1, 1'b0, 1'b0);
         step_ph("c5", 2, 1'b0, 1'b0);
         step_ph("c5", 3, 1'b0, 1'b0);
         step_ph("c5", 0, 1'b0, 1'b0);
      end
      step_ph("c5_bad", 2, 1'b0, 1'b0);
      check("c5.cycles", 32'(cycle_cnt), 32'd5);
      check("c5.err", 32'(err), 32'd1);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check("async.phase", 32'(phase), 32'd0);
      check("async.valid", 32'(phase_valid), 32'd0);
      check("async.err", 32'(err), 32'd0);
      check("async.code", 32'(err_code), 32'd0);
      check("async.dwell", 32'(dwell_cnt), 32'd0);
      check("async.cycle", 32'(cycle_cnt), 32'd0);
      #2 reset = 1'b0;
      step_ph("post_rst", 1, 1'b0, 1'b0);
      check("post_rst.valid", 32'(phase_valid), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         p = m_trk ? m_expect() : $urandom_range(0, 3);
         if (r < 6) p = $urandom_range(0, 3);
         ra = LA_OF[p]; rb = LB_OF[p];
         if (r >= 6 && r < 9) begin
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
         end
         step("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              (r >= 90) && (m_err || r >= 98));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
